// File: rtl/tx_pkg.sv
// Shared constants and state type for the RGMII transmit payload buffer.
package tx_pkg;

   localparam int FRAME_BYTES    = 1024;
   localparam int TX_ADDR_W      = 11;
   localparam int GAP_CYCLES_DEF = 1100;

   typedef enum logic [1:0] {
      FILL = 2'd0,
      HOLD = 2'd1,
      PAD  = 2'd2
   } txbuf_state_t;

endpackage

// File: rtl/tx_bank_ram.sv
// 2-bank payload store: one write port, one registered read port with read-before-write
// behaviour on a same-address collision.
module tx_bank_ram #(
   parameter int ADDR_W = 11,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rstN,
   input  logic              i_wrEn,
   input  logic [ADDR_W-1:0] i_wrAddr,
   input  logic [DATA_W-1:0] i_wrData,
   input  logic [ADDR_W-1:0] i_rdAddr,
   output logic [DATA_W-1:0] o_rdData
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] r_rdData;

   always_ff @(posedge i_clk) begin
      if (i_wrEn) begin
         r_mem[i_wrAddr] <= i_wrData;
      end
   end

   // Only the output register is reset so the array still maps onto block RAM.
   always_ff @(posedge i_clk or negedge i_rstN) begin
      if (!i_rstN) begin
         r_rdData <= '0;
      end else begin
         r_rdData <= r_mem[i_rdAddr];
      end
   end

   assign o_rdData = r_rdData;

endmodule

// File: rtl/tx_frame_buf.sv
// Ping-pong 2x1024-byte payload buffer for the RGMII transmitter; a full bank is committed
// by toggling idx. Define TXBUF_FLUSH_EN to zero-pad and commit a short frame on s_last.
module tx_frame_buf
   import tx_pkg::*;
#(
   parameter int FRAME_LOG2 = 10,
   parameter int GAP_CYCLES = GAP_CYCLES_DEF
) (
   input  logic                clk125,
   input  logic                rst_n,
   input  logic [7:0]          s_data,
   input  logic                s_valid,
   output logic                s_ready,
   input  logic                s_last,
   output logic                idx,
   input  logic [FRAME_LOG2:0] rd_addr,
   output logic [7:0]          rd_data
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);

   txbuf_state_t          r_state;
   logic                  r_sReady;
   logic                  r_idx;
   logic                  r_wrBank;
   logic [FRAME_LOG2-1:0] r_wrPtr;
   logic [GAP_W-1:0]      r_gapCnt;

   logic                  w_accept;
   logic                  w_pad;
   logic                  w_wrEn;
   logic [7:0]            w_wrData;
   logic                  w_lastSlot;
   logic                  w_gapZero;
   logic                  w_commit;
   logic                  w_unusedLast;

   assign w_accept = s_valid & r_sReady;

`ifdef TXBUF_FLUSH_EN
   assign w_pad        = (r_state == PAD);
   assign w_unusedLast = 1'b0;
`else
   assign w_pad        = 1'b0;
   assign w_unusedLast = s_last;
`endif

   assign w_wrEn     = w_accept | w_pad;
   assign w_wrData   = w_pad ? 8'h00 : s_data;
   assign w_lastSlot = &r_wrPtr;
   assign w_gapZero  = (r_gapCnt == '0);

   // A bank commits when its last slot is written (or later, from HOLD) once the
   // previous frame has had GAP_CYCLES to clear the other bank.
   assign w_commit = w_gapZero & ((w_wrEn & w_lastSlot) | (r_state == HOLD));

   always_ff @(posedge clk125 or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= FILL;
         r_sReady <= 1'b1;
         r_idx    <= 1'b1;
         r_wrBank <= 1'b0;
         r_wrPtr  <= '0;
         r_gapCnt <= '0;
      end else if (w_commit) begin
         r_idx    <= r_wrBank;
         r_wrBank <= ~r_wrBank;
         r_wrPtr  <= '0;
         r_gapCnt <= GAP_W'(GAP_CYCLES);
         r_state  <= FILL;
         r_sReady <= 1'b1;
      end else begin
         if (!w_gapZero) begin
            r_gapCnt <= r_gapCnt - GAP_W'(1);
         end
         if (w_wrEn) begin
            r_wrPtr <= r_wrPtr + FRAME_LOG2'(1);
            if (w_lastSlot) begin
               r_state  <= HOLD;
               r_sReady <= 1'b0;
            end
`ifdef TXBUF_FLUSH_EN
            else if (w_accept && s_last) begin
               r_state  <= PAD;
               r_sReady <= 1'b0;
            end
`endif
         end
      end
   end

   tx_bank_ram #(
      .ADDR_W (FRAME_LOG2 + 1),
      .DATA_W (8)
   ) u_ram (
      .i_clk    (clk125),
      .i_rstN   (rst_n),
      .i_wrEn   (w_wrEn),
      .i_wrAddr ({r_wrBank, r_wrPtr}),
      .i_wrData (w_wrData),
      .i_rdAddr (rd_addr),
      .o_rdData (rd_data)
   );

   assign s_ready = r_sReady;
   assign idx     = r_idx;

endmodule

// File: tb/tb_tx_frame_buf.sv
// Directed self-checking bench for tx_frame_buf (default build and TXBUF_FLUSH_EN build).
module tb_tx_frame_buf;

   logic        clk125  = 1'b0;
   logic        rst_n   = 1'b0;
   logic [7:0]  s_data  = 8'h00;
   logic        s_valid = 1'b0;
   logic        s_last  = 1'b0;
   logic [10:0] rd_addr = 11'h000;
   logic        s_ready;
   logic        idx;
   logic [7:0]  rd_data;

   int testsRun    = 0;
   int testsFailed = 0;

   always #4 clk125 = ~clk125;

   tx_frame_buf dut (
      .clk125  (clk125),
      .rst_n   (rst_n),
      .s_data  (s_data),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_last  (s_last),
      .idx     (idx),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // One clock of stimulus; acc reports whether the byte was taken on this edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                input logic [10:0] ra, output logic acc);
      s_valid = v;
      s_data  = d;
      s_last  = l;
      rd_addr = ra;
      acc     = v & s_ready;
      @(posedge clk125);
      #1;
   endtask

   task automatic doReset();
      s_valid = 1'b0;
      s_last  = 1'b0;
      rst_n   = 1'b0;
      repeat (2) @(posedge clk125);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #2ms;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic       acc;
      logic [7:0] d;
      logic [10:0] ra;
      int drops, n, holdCycles, firstHold, toggleCycle, lowCycles, toggles;
      logic prevIdx;

      doReset();
      checkOutput("reset_idx", idx, 1);
      checkOutput("reset_ready", s_ready, 1);
      checkOutput("reset_rddata", rd_data, 0);

      // Test 1: first bank, gap counter is idle so commit lands on the 1024th accept.
      drops = 0;
      for (int i = 0; i < 1024; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 11'h000, acc);
         if (!acc) drops++;
         if (i == 1022) checkOutput("t1_idx_before_last", idx, 1);
      end
      checkOutput("t1_ready_drops", drops, 0);
      checkOutput("t1_idx_after_last", idx, 0);

      // Test 2: bank 1 fills, then HOLD until gap_cnt (1100 at commit) has reached 0.
      n = 0; holdCycles = 0; firstHold = 0; toggleCycle = 0;
      for (int c = 1; c <= 4000 && n < 2048; c++) begin
         d  = (n < 1024) ? 8'(n) : (8'(n) ^ 8'hA5);
         ra = (c <= 1024) ? 11'(c - 1) : 11'h000;
         applyStimulus(1'b1, d, 1'b0, ra, acc);
         if (acc) n++;
         else begin
            holdCycles++;
            if (firstHold == 0) firstHold = c;
         end
         if (c <= 1024) checkOutput($sformatf("t1_ram_%03h", c - 1), rd_data, (c - 1) & 8'hFF);
         if (idx == 1'b1 && toggleCycle == 0) toggleCycle = c;
      end
      checkOutput("t2_bytes_accepted", n, 2048);
      checkOutput("t2_first_hold_cycle", firstHold, 1025);
      checkOutput("t2_hold_cycles", holdCycles, 77);
      checkOutput("t2_toggle_cycle", toggleCycle, 1101);

      // Test 3: read port and bank placement of the second and third blocks.
      checkOutput("t3_ready_in_hold", s_ready, 0);
      applyStimulus(1'b0, 8'h00, 1'b0, 11'h405, acc);
      checkOutput("t3_rd_405", rd_data, 8'h05);
      applyStimulus(1'b0, 8'h00, 1'b0, 11'h4FF, acc);
      checkOutput("t3_rd_4ff", rd_data, 8'hFF);
      applyStimulus(1'b0, 8'h00, 1'b0, 11'h010, acc);
      checkOutput("t3_rd_010", rd_data, 8'hB5);
      applyStimulus(1'b0, 8'h00, 1'b0, 11'h3FF, acc);
      checkOutput("t3_rd_3ff", rd_data, 8'h5A);
      checkOutput("t3_idx_still_1", idx, 1);

      // Tests 4/5: short packet of 10 bytes terminated with s_last.
      doReset();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 8'(8'h11 + i), (i == 9), 11'h000, acc);
      end
`ifdef TXBUF_FLUSH_EN
      lowCycles = 0; toggles = 0; prevIdx = idx;
      for (int c = 1; c <= 1100; c++) begin
         if (!s_ready) lowCycles++;
         applyStimulus(1'b0, 8'h00, 1'b0, 11'h000, acc);
         if (idx != prevIdx) toggles++;
         prevIdx = idx;
      end
      checkOutput("t4_ready_low_cycles", lowCycles, 1014);
      checkOutput("t4_toggles", toggles, 1);
      checkOutput("t4_idx", idx, 0);
      for (int a = 0; a < 1024; a++) begin
         applyStimulus(1'b0, 8'h00, 1'b0, 11'(a), acc);
         checkOutput($sformatf("t4_ram_%03h", a), rd_data, (a < 10) ? (8'h11 + a) : 0);
      end
`else
      lowCycles = 0;
      for (int c = 1; c <= 50; c++) begin
         if (!s_ready) lowCycles++;
         applyStimulus(1'b0, 8'h00, 1'b0, 11'h000, acc);
      end
      checkOutput("t5_ready_low_cycles", lowCycles, 0);
      checkOutput("t5_no_toggle", idx, 1);
      for (int i = 0; i < 1014; i++) begin
         applyStimulus(1'b1, 8'h22, 1'b0, 11'h000, acc);
         if (i == 1012) checkOutput("t5_idx_before_last", idx, 1);
      end
      checkOutput("t5_idx_after_last", idx, 0);
`endif

      // Test 6: asynchronous reset mid-fill discards the partial bank.
      doReset();
      for (int i = 0; i < 500; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + i), 1'b0, 11'h005, acc);
      end
      checkOutput("t6_rd_before_reset", rd_data, 8'h45);
      rst_n = 1'b0;
      #1;
      checkOutput("t6_reset_idx", idx, 1);
      checkOutput("t6_reset_ready", s_ready, 1);
      checkOutput("t6_reset_rddata", rd_data, 0);
      s_valid = 1'b0;
      @(posedge clk125);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 1024; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0, 11'h000, acc);
         if (i == 1022) checkOutput("t6_idx_before_fresh_1024", idx, 1);
      end
      checkOutput("t6_idx_after_fresh_1024", idx, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
